// File: rtl/trap_ctrl_pkg.sv
// Shared encodings for the trap sequencer: SYSTEM instruction words, mcause codes,
// RV64 major opcodes and the sequencer state encoding. Optional illegal trapping: TRAP_CTRL_ILLEGAL_EN.
package trap_ctrl_pkg;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;

    localparam int CAUSE_ECALL_M = 11;
    localparam int CAUSE_BREAK   = 3;
    localparam int CAUSE_ILLEGAL = 2;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_REDIRECT = 2'd3
    } state_t;

    typedef struct packed {
        logic is_ecall;
        logic is_ebreak;
        logic is_mret;
        logic is_illegal;
    } dec_t;

    function automatic logic opcode_known(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
            OPC_OP_IMM, OPC_OP, OPC_OP_IMM_32, OPC_OP_32, OPC_SYSTEM, OPC_MISC_MEM:
                opcode_known = 1'b1;
            default:
                opcode_known = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/trap_decode.sv
// Combinational classifier of the EX instruction word into trap/return sources.
// Illegal-opcode detection is compiled in only with TRAP_CTRL_ILLEGAL_EN.
module trap_decode
    import trap_ctrl_pkg::*;
#(
    parameter int INST_LEN = 32
) (
    input  logic [INST_LEN-1:0] instr,
    output dec_t                dec
);

    always_comb begin
        dec            = '0;
        dec.is_ecall   = (instr == INST_LEN'(INSTR_ECALL));
        dec.is_ebreak  = (instr == INST_LEN'(INSTR_EBREAK));
        dec.is_mret    = (instr == INST_LEN'(INSTR_MRET));
`ifdef TRAP_CTRL_ILLEGAL_EN
        // Compressed encodings are not supported, so any non-11 low pair is illegal too.
        dec.is_illegal = (instr[1:0] != 2'b11) || !opcode_known(instr[6:0]);
`else
        dec.is_illegal = 1'b0;
`endif
    end

endmodule

// File: rtl/trap_ctrl.sv
// Exception/return sequencer: detect in EX, drain memory, strobe the CSR file, redirect fetch.
// Illegal-opcode traps (cause 2) are enabled by defining TRAP_CTRL_ILLEGAL_EN.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int INST_LEN  = 32,
    parameter int DRAIN_MAX = 255,
    parameter int CNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_valid_i,
    input  logic                ex_kill_i,
    input  logic [XLEN-1:0]     ex_pc_i,
    input  logic [INST_LEN-1:0] ex_instr_i,
    input  logic                mem_busy_i,
    input  logic [XLEN-1:0]     mtvec_i,
    input  logic [XLEN-1:0]     mepc_i,
    input  logic                redirect_ready_i,
    output logic                stall_o,
    output logic                flush_o,
    output logic                trap_o,
    output logic [XLEN-1:0]     trap_pc_o,
    output logic [XLEN-1:0]     trap_cause_o,
    output logic                mret_o,
    output logic                redirect_valid_o,
    output logic [XLEN-1:0]     redirect_pc_o,
    output logic                drain_timeout_o
);

    dec_t             dec;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_inc;
    logic             is_mret_q;
    logic             detect;
    logic             drain_hit;
    logic             drain_exit;
    logic [XLEN-1:0]  cause_sel;

    trap_decode #(.INST_LEN(INST_LEN)) u_decode (
        .instr (ex_instr_i),
        .dec   (dec)
    );

    assign detect = ex_valid_i && !ex_kill_i && (state == ST_IDLE) &&
                    (dec.is_ecall || dec.is_ebreak || dec.is_mret || dec.is_illegal);

    // Compare the post-increment count so the forced exit lands after exactly DRAIN_MAX cycles.
    assign cnt_inc    = {1'b0, cnt} + 1'b1;
    assign drain_hit  = (cnt_inc == (CNT_W+1)'(DRAIN_MAX));
    assign drain_exit = !mem_busy_i || drain_hit;

    always_comb begin
        cause_sel = '0;
        if (dec.is_ecall) begin
            cause_sel = XLEN'(CAUSE_ECALL_M);
        end else if (dec.is_ebreak) begin
            cause_sel = XLEN'(CAUSE_BREAK);
        end else if (dec.is_illegal) begin
            cause_sel = XLEN'(CAUSE_ILLEGAL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        flush_o          = 1'b0;
        trap_o           = 1'b0;
        mret_o           = 1'b0;
        redirect_valid_o = 1'b0;
        case (state)
            ST_IDLE: begin
                if (detect) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_exit) state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                flush_o   = 1'b1;
                trap_o    = !is_mret_q;
                mret_o    = is_mret_q;
                state_nxt = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                redirect_valid_o = 1'b1;
                if (redirect_ready_i) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        stall_o = detect || (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt             <= '0;
            is_mret_q       <= 1'b0;
            trap_pc_o       <= '0;
            trap_cause_o    <= '0;
            redirect_pc_o   <= '0;
            drain_timeout_o <= 1'b0;
        end else begin
            if (detect) begin
                trap_pc_o    <= ex_pc_i;
                trap_cause_o <= cause_sel;
                is_mret_q    <= dec.is_mret;
                cnt          <= '0;
            end
            if (state == ST_DRAIN) begin
                if (cnt != CNT_W'(DRAIN_MAX)) cnt <= cnt_inc[CNT_W-1:0];
                if (drain_hit) drain_timeout_o <= 1'b1;
                // Target is frozen here so it stays stable for the whole handshake.
                if (drain_exit) redirect_pc_o <= is_mret_q ? mepc_i : (mtvec_i & ~XLEN'(3));
            end
        end
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Exception/return sequencer that sits directly upstream of the CSR file.
- Watches the instruction leaving EX and detects ECALL, EBREAK, MRET and, optionally, illegal opcodes.
- Drains outstanding memory traffic, then issues the one-cycle trap strobe with faulting PC and cause to the CSR file.
- Flushes the pipeline and redirects fetch to mtvec (trap) or mepc (MRET) through a valid/ready handshake.

Parameters:
- XLEN, 64, datapath/PC width.
- INST_LEN, 32, instruction width.
- DRAIN_MAX, 255, maximum cycles spent waiting for mem_busy_i to drop before forcing the commit.
- CNT_W, 8, width of the drain counter; must satisfy 2^CNT_W > DRAIN_MAX.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid_i  in  1  EX holds a valid instruction this cycle
- ex_kill_i  in  1  EX instruction squashed by an older redirect this cycle
- ex_pc_i  in  XLEN  PC of the EX instruction
- ex_instr_i  in  INST_LEN  EX instruction word
- mem_busy_i  in  1  older load/store still outstanding in MEM/WB
- mtvec_i  in  XLEN  current mtvec from the CSR file
- mepc_i  in  XLEN  current mepc from the CSR file
- redirect_ready_i  in  1  fetch accepts the redirect
- stall_o  out  1  freeze IF/ID/EX
- flush_o  out  1  one-cycle kill of IF/ID/EX contents
- trap_o  out  1  one-cycle strobe to the CSR file (mepc <= trap_pc_o)
- trap_pc_o  out  XLEN  captured faulting PC
- trap_cause_o  out  XLEN  mcause value: 11 ECALL-M, 3 EBREAK, 2 illegal
- mret_o  out  1  one-cycle strobe to the CSR file for MRET
- redirect_valid_o  out  1  redirect request to fetch
- redirect_pc_o  out  XLEN  redirect target
- drain_timeout_o  out  1  sticky flag: a drain reached DRAIN_MAX

Behaviour:
- Opcode decode:
  - ECALL = 0x00000073
  - EBREAK = 0x00100073
  - MRET = 0x30200073
- detect = ex_valid_i & ~ex_kill_i & (one of the above) & (state == IDLE).
- On the detect edge, latch:
  - trap_pc_o <= ex_pc_i
  - trap_cause_o <= the code above (0 for MRET)
  - is_mret flag
  - counter cleared
- States IDLE, DRAIN, COMMIT, REDIRECT:
  - IDLE -> DRAIN on detect.
  - DRAIN -> COMMIT when ~mem_busy_i or counter == DRAIN_MAX. The counter increments each DRAIN cycle and saturates. Hitting DRAIN_MAX sets drain_timeout_o, which is cleared only by reset.
  - COMMIT -> REDIRECT unconditionally. In COMMIT:
    - flush_o = 1
    - trap_o = ~is_mret
    - mret_o = is_mret
  - REDIRECT: redirect_valid_o = 1. redirect_pc_o = is_mret ? mepc_i : {mtvec_i[XLEN-1:2], 2'b00}; the value is registered on COMMIT entry and held stable while valid. Go to IDLE on redirect_valid_o & redirect_ready_i.
- stall_o = detect | (state != IDLE), combinational.
- Minimum latency, mem idle and ready high:
  - detect in cycle N
  - DRAIN N+1
  - COMMIT N+2 (trap_o)
  - REDIRECT N+3
  - IDLE N+4
- Boundary conditions:
  - Trap candidates arriving while not in IDLE are ignored; the stall guarantees EX holds.
  - ex_kill_i in the detect cycle suppresses detect.
  - redirect_valid_o never drops before ready.
- Reset, at any time, including mid-sequence:
  - state IDLE, counter 0
  - all strobes, redirect_valid_o and drain_timeout_o = 0
  - trap_pc_o, trap_cause_o, redirect_pc_o = 0

Optional Feature:
- Macro: TRAP_CTRL_ILLEGAL_EN.
- Defined: opcode[6:0] not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, OP-IMM-32, OP-32, SYSTEM, MISC-MEM}, or instr[1:0] != 2'b11, is also a detect source, with cause 2.
- Undefined: unknown opcodes are never trapped; cause 2 is unreachable.

Decomposition:
- Shared package/header:
  - ECALL/EBREAK/MRET encodings
  - cause constants (CAUSE_ECALL_M=11, CAUSE_BREAK=3, CAUSE_ILLEGAL=2)
  - opcode constants
  - 2-bit state encoding
- Sub-module trap_decode, combinational: instruction word -> {is_ecall, is_ebreak, is_mret, is_illegal}.
- FSM, counter and capture registers stay in trap_ctrl.

Test Plan:
- ECALL at pc 0x80000010, mem idle, ready=1, mtvec=0x80000101 -> trap_o in N+2 with trap_pc_o=0x80000010, trap_cause_o=11; redirect_pc_o=0x80000100 in N+3.
- MRET with mepc=0x80000014, ready low for 3 cycles -> mret_o pulse, trap_o=0; redirect_valid_o held 4 cycles with a stable PC; IDLE after handshake.
- EBREAK with mem_busy_i high 5 cycles -> 5 DRAIN cycles, then trap_o, cause=3, stall_o high throughout.
- mem_busy_i stuck high, DRAIN_MAX=255 -> forced COMMIT after 255 DRAIN cycles; drain_timeout_o=1 and stays 1.
- ECALL with ex_kill_i=1 -> no stall_o, no trap_o; a second ECALL presented during REDIRECT is ignored.
- rst_n asserted in DRAIN -> all outputs 0 immediately. With TRAP_CTRL_ILLEGAL_EN, instr 0x0000007F -> cause 2.
